sma_tag_encoder: RTL and testbench

Builds tagged pointers for the SMA bounds-checking datapath. It accepts an object base address and a byte length, then searches for the smallest block-size exponent `b_size` and block count `l_size` that cover the object. It returns `{b_size, l_size, base}` in the same layout the SMA address-check engine decodes. It sits on the allocation path (malloc/stack-frame setup), the producer end of the tagged-pointer format.

---
 rtl/sma_pkg.sv | 45 ++++
 rtl/sma_tag_encoder_if.sv | 27 ++
 rtl/sma_len_units.sv | 25 ++
 rtl/sma_tag_encoder.sv | 142 ++++++++++++++
 tb/tb_sma_tag_encoder.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/sma_pkg.sv
// Shared definitions for the SMA tagged-pointer format.
// Tagged pointer layout: [63:58] b_size, [57:54] l_size, [53:48] zero, [47:0] base.
// Also holds the encoder state enum and small pointer helpers.
package sma_pkg;

  localparam int WORD_WIDTH   = 64;
  localparam int BSIZE_WIDTH  = 6;
  localparam int LENGTH_WIDTH = 4;
  localparam int PTR_WIDTH    = 48;
  localparam int MAX_BSIZE    = PTR_WIDTH - LENGTH_WIDTH;

  localparam int BSIZE_LSB = WORD_WIDTH - BSIZE_WIDTH;
  localparam int LSIZE_LSB = BSIZE_LSB - LENGTH_WIDTH;
  localparam int PAD_WIDTH = LSIZE_LSB - PTR_WIDTH;

  localparam logic [BSIZE_WIDTH-1:0] MAX_BSIZE_B = BSIZE_WIDTH'(MAX_BSIZE);
  // Largest block count an l_size field can hold, widened to the unit-count width.
  localparam logic [WORD_WIDTH:0] UNITS_MAX =
    {{(WORD_WIDTH + 1 - LENGTH_WIDTH){1'b0}}, {LENGTH_WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } enc_state_e;

  function automatic logic [WORD_WIDTH-1:0] pack_tagged_ptr(
    input logic [BSIZE_WIDTH-1:0]  b_size,
    input logic [LENGTH_WIDTH-1:0] l_size,
    input logic [PTR_WIDTH-1:0]    base
  );
    return {b_size, l_size, {PAD_WIDTH{1'b0}}, base};
  endfunction

  // A base must sit on a 2^(b_size+4) boundary; b_size+4 never exceeds PTR_WIDTH.
  function automatic logic base_misaligned(
    input logic [PTR_WIDTH-1:0]   base,
    input logic [BSIZE_WIDTH-1:0] b_size
  );
    logic [PTR_WIDTH-1:0] mask;
    mask = ~({PTR_WIDTH{1'b1}} << (b_size + 6'd4));
    return |(base & mask);
  endfunction

endpackage

// File: rtl/sma_tag_encoder_if.sv
// Request/response bundle of the tag encoder.
// slave : encoder side (takes requests, produces responses, reports busy).
// master: requester side.
interface sma_tag_encoder_if;
  import sma_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [PTR_WIDTH-1:0]  req_base;
  logic [WORD_WIDTH-1:0] req_len;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WORD_WIDTH-1:0] rsp_tagged_pointer;
  logic                  rsp_err_size;
  logic                  rsp_err_align;
  logic                  busy;

  modport slave (
    input  req_valid, req_base, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_tagged_pointer, rsp_err_size, rsp_err_align, busy
  );

  modport master (
    output req_valid, req_base, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_tagged_pointer, rsp_err_size, rsp_err_align, busy
  );
endinterface

// File: rtl/sma_len_units.sv
// Number of 2^b-byte blocks needed to cover len bytes (rounded up), and
// whether that count fits in an l_size field.
// Ports: len_i object length, b_i candidate exponent,
//        units_o block count (low l_size bits, meaningful when fits_o),
//        fits_o count <= 15.
module sma_len_units
  import sma_pkg::*;
(
  input  logic [WORD_WIDTH-1:0]   len_i,
  input  logic [BSIZE_WIDTH-1:0]  b_i,
  output logic [LENGTH_WIDTH-1:0] units_o,
  output logic                    fits_o
);

  logic [WORD_WIDTH-1:0] rem_mask_s;
  logic [WORD_WIDTH:0]   units_full_s;

  // One extra bit so the round-up of an all-ones length cannot wrap.
  assign rem_mask_s   = ~({WORD_WIDTH{1'b1}} << b_i);
  assign units_full_s = ({1'b0, len_i} >> b_i)
                      + {{WORD_WIDTH{1'b0}}, |(len_i & rem_mask_s)};
  assign fits_o       = (units_full_s <= UNITS_MAX);
  assign units_o      = units_full_s[LENGTH_WIDTH-1:0];

endmodule

// File: rtl/sma_tag_encoder.sv
// Tagged-pointer encoder: searches the smallest b_size (one candidate per
// cycle) whose block count fits l_size, and returns {b_size, l_size, 0, base}.
// Ports: clk, rst_n (async active-low), enc (sma_tag_encoder_if.slave):
//        req_valid/req_ready/req_base/req_len in, rsp_valid/rsp_ready/
//        rsp_tagged_pointer/rsp_err_size/rsp_err_align out, busy.
// Widths come from sma_pkg.
// Option macro SMA_ENC_ALIGN_CHK_EN: flag bases not aligned to 2^(b_size+4);
// when undefined rsp_err_align stays 0.
module sma_tag_encoder
  import sma_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  sma_tag_encoder_if.slave   enc
);

  enc_state_e            state_q, state_d;
  logic [BSIZE_WIDTH-1:0] b_q, b_d;
  logic [PTR_WIDTH-1:0]   base_q, base_d;
  logic [WORD_WIDTH-1:0]  len_q, len_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [WORD_WIDTH-1:0]  rsp_ptr_q, rsp_ptr_d;
  logic                   err_size_q, err_size_d;
  logic                   err_align_q, err_align_d;

  logic [LENGTH_WIDTH-1:0] units_s;
  logic                    fits_s;
  logic [LENGTH_WIDTH-1:0] l_size_s;
  logic                    err_size_s;
  logic                    err_align_s;

  sma_len_units u_len_units (
    .len_i   (len_q),
    .b_i     (b_q),
    .units_o (units_s),
    .fits_o  (fits_s)
  );

  // State, search and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      b_q         <= '0;
      base_q      <= '0;
      len_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_ptr_q   <= '0;
      err_size_q  <= 1'b0;
      err_align_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      b_q         <= b_d;
      base_q      <= base_d;
      len_q       <= len_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ptr_q   <= rsp_ptr_d;
      err_size_q  <= err_size_d;
      err_align_q <= err_align_d;
    end
  end

  // Next-state logic and response construction.
  always_comb begin
    state_d     = state_q;
    b_d         = b_q;
    base_d      = base_q;
    len_d       = len_q;
    rsp_valid_d = rsp_valid_q;
    rsp_ptr_d   = rsp_ptr_q;
    err_size_d  = err_size_q;
    err_align_d = err_align_q;
    l_size_s    = '0;
    err_size_s  = 1'b0;
    err_align_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enc.req_valid) begin
          base_d  = enc.req_base;
          len_d   = enc.req_len;
          b_d     = '0;
          state_d = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SCAN: begin
        if (fits_s || (b_q == MAX_BSIZE_B)) begin
          if (fits_s) begin
            l_size_s   = units_s;
            err_size_s = 1'b0;
          end else begin
            l_size_s   = '0;
            err_size_s = 1'b1;
          end
`ifdef SMA_ENC_ALIGN_CHK_EN
          err_align_s = base_misaligned(base_q, b_q);
`else
          err_align_s = 1'b0;
`endif
          // Any error leaves a zero-length pointer that still carries the base.
          if (err_size_s || err_align_s) begin
            l_size_s = '0;
          end else begin
            l_size_s = l_size_s;
          end
          rsp_ptr_d   = pack_tagged_ptr(b_q, l_size_s, base_q);
          err_size_d  = err_size_s;
          err_align_d = err_align_s;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          b_d     = b_q + 6'd1;
          state_d = ST_SCAN;
        end
      end

      ST_RESP: begin
        if (enc.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  assign enc.req_ready          = (state_q == ST_IDLE);
  assign enc.busy               = (state_q != ST_IDLE);
  assign enc.rsp_valid          = rsp_valid_q;
  assign enc.rsp_tagged_pointer = rsp_ptr_q;
  assign enc.rsp_err_size       = err_size_q;
  assign enc.rsp_err_align      = err_align_q;

endmodule

// File: tb/tb_sma_tag_encoder.sv
// Self-checking bench for sma_tag_encoder: directed table, hold/reset
// sequences, and random requests against a division-based reference model.
module tb_sma_tag_encoder;
  import sma_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sma_tag_encoder_if ifc();

  sma_tag_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .enc   (ifc)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [47:0] base;
    logic [63:0] len;
    logic [63:0] ptr;
    logic        es;
    logic        ea;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Smallest b with ceil(len / 2^b) <= 15, by plain division.
  function automatic void ref_model(input logic [47:0] base, input logic [63:0] len,
                                    output logic [63:0] ptr, output logic es,
                                    output logic ea, output int lat);
    logic [64:0] units;
    logic [64:0] blk;
    int          bfin;
    logic [3:0]  lsz;
    bit          found;
    found = 0;
    bfin  = 44;
    lsz   = 4'd0;
    for (int b = 0; b <= 44; b++) begin
      if (!found) begin
        blk   = 65'd1 << b;
        units = ({1'b0, len} + blk - 65'd1) / blk;
        if (units <= 65'd15) begin
          found = 1;
          bfin  = b;
          lsz   = units[3:0];
        end
      end
    end
    es = !found;
    ea = 1'b0;
`ifdef SMA_ENC_ALIGN_CHK_EN
    ea = (({16'd0, base} % (64'd1 << (bfin + 4))) != 64'd0);
`endif
    if (es || ea) lsz = 4'd0;
    ptr = {6'(bfin), lsz, 6'd0, base};
    lat = bfin + 1;
  endfunction

  task automatic do_req(input logic [47:0] base, input logic [63:0] len,
                        output logic [63:0] ptr, output logic es, output logic ea,
                        output int lat, output bit ok);
    @(negedge clk);
    chk("ready_before_req", {63'd0, ifc.req_ready}, 64'd1);
    ifc.req_valid = 1'b1;
    ifc.req_base  = base;
    ifc.req_len   = len;
    @(posedge clk);
    #1 ifc.req_valid = 1'b0;
    lat = 0;
    ok  = 0;
    while (lat < 60 && !ok) begin
      @(posedge clk);
      lat++;
      #1;
      if (ifc.rsp_valid) ok = 1;
    end
    ptr = ifc.rsp_tagged_pointer;
    es  = ifc.rsp_err_size;
    ea  = ifc.rsp_err_align;
    @(negedge clk);
    ifc.rsp_ready = 1'b1;
    @(posedge clk);
    #1 ifc.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] ptr, eptr, r64;
    logic        es, ea, ees, eea;
    int          lat, elat;
    bit          ok, seen;
    logic [47:0] base;
    logic [63:0] len;

    vecs[0] = '{48'h1000, 64'd16, 64'h0600_0000_0000_1000, 1'b0, 1'b0, 2};
    vecs[1] = '{48'h2000, 64'd0,  64'h0000_0000_0000_2000, 1'b0, 1'b0, 1};
    vecs[2] = '{48'h10,   64'd15, 64'h03C0_0000_0000_0010, 1'b0, 1'b0, 1};
`ifdef SMA_ENC_ALIGN_CHK_EN
    vecs[3] = '{48'h1008, 64'd100, 64'h0C00_0000_0000_1008, 1'b0, 1'b1, 4};
`else
    vecs[3] = '{48'h1008, 64'd100, 64'h0F40_0000_0000_1008, 1'b0, 1'b0, 4};
`endif
    vecs[4] = '{48'h0, 64'h8000_0000_0000_0000, 64'hB000_0000_0000_0000, 1'b1, 1'b0, 45};
    vecs[5] = '{48'h0, 64'd240, 64'h13C0_0000_0000_0000, 1'b0, 1'b0, 5};
    vecs[6] = '{48'h0, 64'd241, 64'h1600_0000_0000_0000, 1'b0, 1'b0, 6};
    vecs[7] = '{48'h0, 64'h0000_F000_0000_0000, 64'hB3C0_0000_0000_0000, 1'b0, 1'b0, 45};
    vecs[8] = '{48'h0, 64'h0000_F000_0000_0001, 64'hB000_0000_0000_0000, 1'b1, 1'b0, 45};

    rst_n         = 1'b0;
    ifc.req_valid = 1'b0;
    ifc.req_base  = '0;
    ifc.req_len   = '0;
    ifc.rsp_ready = 1'b0;
    #12;
    chk("rst_req_ready", {63'd0, ifc.req_ready}, 64'd1);
    chk("rst_rsp_valid", {63'd0, ifc.rsp_valid}, 64'd0);
    chk("rst_ptr", ifc.rsp_tagged_pointer, 64'd0);
    chk("rst_err_size", {63'd0, ifc.rsp_err_size}, 64'd0);
    chk("rst_err_align", {63'd0, ifc.rsp_err_align}, 64'd0);
    chk("rst_busy", {63'd0, ifc.busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      do_req(vecs[i].base, vecs[i].len, ptr, es, ea, lat, ok);
      chk("vec_timeout", {63'd0, ok}, 64'd1);
      chk("vec_ptr", ptr, vecs[i].ptr);
      chk("vec_err_size", {63'd0, es}, {63'd0, vecs[i].es});
      chk("vec_err_align", {63'd0, ea}, {63'd0, vecs[i].ea});
      chk("vec_latency", 64'(lat), 64'(vecs[i].lat));
    end

    // Response held under back-pressure while a new request is offered.
    @(negedge clk);
    ifc.req_valid = 1'b1;
    ifc.req_base  = 48'h10;
    ifc.req_len   = 64'd15;
    @(posedge clk);
    #1;
    ifc.req_base = 48'hABC0;
    ifc.req_len  = 64'd1;
    ok = 0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk);
      if (ifc.rsp_valid) ok = 1;
    end
    chk("hold_timeout", {63'd0, ok}, 64'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_ptr", ifc.rsp_tagged_pointer, 64'h03C0_0000_0000_0010);
      chk("hold_valid", {63'd0, ifc.rsp_valid}, 64'd1);
      chk("hold_ready", {63'd0, ifc.req_ready}, 64'd0);
    end
    ifc.req_valid = 1'b0;
    ifc.rsp_ready = 1'b1;
    @(posedge clk);
    #1 ifc.rsp_ready = 1'b0;
    @(negedge clk);
    chk("hold_after_valid", {63'd0, ifc.rsp_valid}, 64'd0);
    chk("hold_after_ready", {63'd0, ifc.req_ready}, 64'd1);
    chk("hold_after_busy", {63'd0, ifc.busy}, 64'd0);

    // Reset during the search drops the request.
    ifc.req_valid = 1'b1;
    ifc.req_base  = 48'h0;
    ifc.req_len   = 64'h0000_0100_0000_0000;
    @(posedge clk);
    #1 ifc.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("scan_busy", {63'd0, ifc.busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {63'd0, ifc.rsp_valid}, 64'd0);
    chk("midrst_ready", {63'd0, ifc.req_ready}, 64'd1);
    chk("midrst_busy", {63'd0, ifc.busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (ifc.rsp_valid) seen = 1;
    end
    chk("midrst_no_rsp", {63'd0, seen}, 64'd0);
    chk("midrst_idle", {63'd0, ifc.req_ready}, 64'd1);

    // Random requests against the reference model.
    for (int n = 0; n < 30; n++) begin
      r64  = {$urandom, $urandom};
      base = r64[47:0];
      if ($urandom_range(0, 1) == 1) base = base & ~48'hF_FFFF;
      r64  = {$urandom, $urandom};
      len  = r64 >> $urandom_range(0, 63);
      ref_model(base, len, eptr, ees, eea, elat);
      do_req(base, len, ptr, es, ea, lat, ok);
      chk("rnd_timeout", {63'd0, ok}, 64'd1);
      chk("rnd_ptr", ptr, eptr);
      chk("rnd_err_size", {63'd0, es}, {63'd0, ees});
      chk("rnd_err_align", {63'd0, ea}, {63'd0, eea});
      chk("rnd_latency", 64'(lat), 64'(elat));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
